// File: rtl/dmem_responder.sv
// Word-addressed data RAM serving one load/store at a time behind the execution stage,
// with a fixed number of wait states, a pipeline hold flag and a one-cycle acknowledge.
module dmem_responder #(
    parameter int          DEPTH       = 4096,
    parameter int          WAIT_CYCLES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h1000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_req_i,
    input  logic        mem_wr_en_i,
    input  logic [31:0] mem_rd_addr_i,
    input  logic [31:0] mem_wr_addr_i,
    input  logic [31:0] mem_data_i,
    output logic [31:0] mem_data_o,
    output logic        mem_ack_o,
    output logic        mem_err_o,
    output logic        hold_flag_o
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [3:0]     r_cnt;
    logic [AW-1:0]  r_idx;
    logic [31:0]    r_wdata;
    logic           r_wr;
    logic           r_err;
    logic [31:0]    r_data;
    logic           r_ack;
    logic           r_err_o;
    logic [31:0]    r_mem [DEPTH];

    logic [31:0]    w_addr;
    logic [31:0]    w_off;
    logic           w_err;
    logic [AW-1:0]  w_idx;
    logic           w_accept;
    logic           w_access;
    logic [AW-1:0]  w_acc_idx;
    logic [31:0]    w_acc_wdata;
    logic           w_acc_wr;
    logic           w_acc_err;
    logic           w_ram_we;

    function automatic logic addr_err(input logic [31:0] addr, input logic [31:0] off);
        return (addr < BASE_ADDR) || ((off >> 2) >= 32'(DEPTH)) || (addr[1:0] != 2'b00);
    endfunction

    assign w_addr = mem_wr_en_i ? mem_wr_addr_i : mem_rd_addr_i;
    assign w_off  = w_addr - BASE_ADDR;
    assign w_err  = addr_err(w_addr, w_off);
    assign w_idx  = w_off[AW+1:2];

    // Next state, accept/access strobes and the operand set used on the access edge
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_access    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (mem_req_i) begin
                    w_accept = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        w_access    = 1'b1;
                        w_state_nxt = S_ACK;
                    end else begin
                        w_state_nxt = S_WAIT;
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_WAIT: begin
                if (!mem_req_i) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == 4'd1) begin
                    w_access    = 1'b1;
                    w_state_nxt = S_ACK;
                end else begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_ACK:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase

        // With zero wait states the access happens on the accept edge, before the latches load
        if (r_state == S_IDLE) begin
            w_acc_idx   = w_idx;
            w_acc_wdata = mem_data_i;
            w_acc_wr    = mem_wr_en_i;
            w_acc_err   = w_err;
        end else begin
            w_acc_idx   = r_idx;
            w_acc_wdata = r_wdata;
            w_acc_wr    = r_wr;
            w_acc_err   = r_err;
        end
    end

    assign w_ram_we    = rst & w_access & w_acc_wr & ~w_acc_err;
    assign hold_flag_o = ((r_state == S_IDLE) && mem_req_i) || (r_state == S_WAIT);
    assign mem_data_o  = r_data;
    assign mem_ack_o   = r_ack;
    assign mem_err_o   = r_err_o;

    // Control state, request latches and registered response
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_idx   <= '0;
            r_wdata <= 32'd0;
            r_wr    <= 1'b0;
            r_err   <= 1'b0;
            r_data  <= 32'd0;
            r_ack   <= 1'b0;
            r_err_o <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_idx   <= w_idx;
                r_wdata <= mem_data_i;
                r_wr    <= mem_wr_en_i;
                r_err   <= w_err;
                r_cnt   <= 4'(WAIT_CYCLES);
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt - 4'd1;
            end else begin
                r_cnt <= r_cnt;
            end
            r_ack   <= w_access;
            r_err_o <= w_access & w_acc_err;
            if (w_access && !w_acc_wr) begin
                r_data <= w_acc_err ? 32'd0 : r_mem[w_acc_idx];
            end else begin
                r_data <= r_data;
            end
        end
    end

    // RAM array; contents survive reset
    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            r_mem[w_acc_idx] <= w_acc_wdata;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances with 0, 1 and 3 wait states.
module tb_dmem_responder;

    logic              clk;
    logic              rst;
    logic [2:0]        req;
    logic [2:0]        wr_en;
    logic [2:0][31:0]  rd_addr;
    logic [2:0][31:0]  wr_addr;
    logic [2:0][31:0]  wdata;
    logic [2:0][31:0]  rdata;
    logic [2:0]        ack;
    logic [2:0]        err;
    logic [2:0]        hold;

    int n_checks = 0;
    int n_errors = 0;

    dmem_responder #(.DEPTH(4096), .WAIT_CYCLES(0), .BASE_ADDR(32'h1000_0000)) u_w0 (
        .clk(clk), .rst(rst), .mem_req_i(req[0]), .mem_wr_en_i(wr_en[0]),
        .mem_rd_addr_i(rd_addr[0]), .mem_wr_addr_i(wr_addr[0]), .mem_data_i(wdata[0]),
        .mem_data_o(rdata[0]), .mem_ack_o(ack[0]), .mem_err_o(err[0]), .hold_flag_o(hold[0]));

    dmem_responder #(.DEPTH(4096), .WAIT_CYCLES(1), .BASE_ADDR(32'h1000_0000)) u_w1 (
        .clk(clk), .rst(rst), .mem_req_i(req[1]), .mem_wr_en_i(wr_en[1]),
        .mem_rd_addr_i(rd_addr[1]), .mem_wr_addr_i(wr_addr[1]), .mem_data_i(wdata[1]),
        .mem_data_o(rdata[1]), .mem_ack_o(ack[1]), .mem_err_o(err[1]), .hold_flag_o(hold[1]));

    dmem_responder #(.DEPTH(4096), .WAIT_CYCLES(3), .BASE_ADDR(32'h1000_0000)) u_w3 (
        .clk(clk), .rst(rst), .mem_req_i(req[2]), .mem_wr_en_i(wr_en[2]),
        .mem_rd_addr_i(rd_addr[2]), .mem_wr_addr_i(wr_addr[2]), .mem_data_i(wdata[2]),
        .mem_data_o(rdata[2]), .mem_ack_o(ack[2]), .mem_err_o(err[2]), .hold_flag_o(hold[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int k, input logic wr, input logic [31:0] addr, input logic [31:0] d);
        req[k]   = 1'b1;
        wr_en[k] = wr;
        // the unused address is deliberately out of window so a wrong address mux errors
        rd_addr[k] = wr ? 32'h0000_0000 : addr;
        wr_addr[k] = wr ? addr : 32'h0000_0000;
        wdata[k]   = wr ? d : 32'hFFFF_FFFF;
    endtask

    // One complete request: checks latency, hold cycles, err and (optionally) read data
    task automatic access(input int k, input logic wr, input logic [31:0] addr, input logic [31:0] d,
                          input int w, input logic exp_err, input logic chk_data,
                          input logic [31:0] exp_data);
        int   lat;
        int   holds;
        logic seen;
        @(negedge clk);
        set_req(k, wr, addr, d);
        #1;
        check_eq("hold_on_req", 32'(hold[k]), 32'd1);
        holds = 1;
        lat   = 0;
        seen  = 1'b0;
        @(posedge clk);
        while (!seen && lat < 20) begin
            @(negedge clk);
            lat++;
            if (ack[k]) seen = 1'b1;
            else if (hold[k]) holds++;
        end
        check_eq("ack_seen", 32'(seen), 32'd1);
        check_eq("ack_latency", 32'(lat), 32'(w + 1));
        check_eq("hold_cycles", 32'(holds), 32'(w + 1));
        check_eq("hold_in_ack", 32'(hold[k]), 32'd0);
        check_eq("err", 32'(err[k]), 32'(exp_err));
        if (chk_data) check_eq("rdata", rdata[k], exp_data);
        req[k] = 1'b0;
        @(negedge clk);
        check_eq("ack_one_cycle", 32'(ack[k]), 32'd0);
        check_eq("err_one_cycle", 32'(err[k]), 32'd0);
    endtask

    initial begin
        int acks;
        rst     = 1'b0;
        req     = '0;
        wr_en   = '0;
        rd_addr = '0;
        wr_addr = '0;
        wdata   = '0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check_eq("rst_rdata", rdata[k], 32'd0);
            check_eq("rst_ack", 32'(ack[k]), 32'd0);
            check_eq("rst_err", 32'(err[k]), 32'd0);
            check_eq("rst_hold", 32'(hold[k]), 32'd0);
        end
        rst = 1'b1;

        // known prior contents, then reset in the middle of a write's WAIT
        access(1, 1'b1, 32'h1000_0010, 32'h1111_1111, 1, 1'b0, 1'b1, 32'd0);
        access(1, 1'b0, 32'h1000_0010, 32'd0, 1, 1'b0, 1'b1, 32'h1111_1111);
        @(negedge clk);
        set_req(1, 1'b1, 32'h1000_0010, 32'hDEAD_BEEF);
        @(posedge clk);
        @(negedge clk);
        check_eq("hold_in_wait", 32'(hold[1]), 32'd1);
        req[1] = 1'b0;
        rst    = 1'b0;
        #1;
        check_eq("midrst_rdata", rdata[1], 32'd0);
        check_eq("midrst_ack", 32'(ack[1]), 32'd0);
        check_eq("midrst_err", 32'(err[1]), 32'd0);
        check_eq("midrst_hold", 32'(hold[1]), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_eq("post_rst_hold", 32'(hold[1]), 32'd0);
        access(1, 1'b0, 32'h1000_0010, 32'd0, 1, 1'b0, 1'b1, 32'h1111_1111);

        // write/read round trip with one wait state
        access(1, 1'b1, 32'h1000_0010, 32'hDEAD_BEEF, 1, 1'b0, 1'b1, 32'h1111_1111);
        access(1, 1'b0, 32'h1000_0010, 32'd0, 1, 1'b0, 1'b1, 32'hDEAD_BEEF);

        // zero and three wait states
        access(0, 1'b1, 32'h1000_0004, 32'hA5A5_0001, 0, 1'b0, 1'b0, 32'd0);
        access(0, 1'b0, 32'h1000_0004, 32'd0, 0, 1'b0, 1'b1, 32'hA5A5_0001);
        access(2, 1'b1, 32'h1000_0020, 32'h0BAD_F00D, 3, 1'b0, 1'b0, 32'd0);
        access(2, 1'b0, 32'h1000_0020, 32'd0, 3, 1'b0, 1'b1, 32'h0BAD_F00D);

        // error cases
        access(1, 1'b1, 32'h1000_0000, 32'hCAFE_0000, 1, 1'b0, 1'b0, 32'd0);
        access(1, 1'b0, 32'h1000_0000, 32'd0, 1, 1'b0, 1'b1, 32'hCAFE_0000);
        access(1, 1'b1, 32'h1000_4000, 32'h5555_5555, 1, 1'b1, 1'b1, 32'hCAFE_0000);
        access(1, 1'b0, 32'h1000_0000, 32'd0, 1, 1'b0, 1'b1, 32'hCAFE_0000);
        access(1, 1'b0, 32'h0FFF_FFFC, 32'd0, 1, 1'b1, 1'b1, 32'd0);
        access(1, 1'b0, 32'h1000_0010, 32'd0, 1, 1'b0, 1'b1, 32'hDEAD_BEEF);
        access(1, 1'b0, 32'h1000_0002, 32'd0, 1, 1'b1, 1'b1, 32'd0);

        // abort one cycle into WAIT
        @(negedge clk);
        set_req(2, 1'b1, 32'h1000_0020, 32'h1234_5678);
        @(posedge clk);
        @(negedge clk);
        check_eq("abort_hold_wait", 32'(hold[2]), 32'd1);
        req[2] = 1'b0;
        acks = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ack[2]) acks++;
        end
        check_eq("abort_no_ack", 32'(acks), 32'd0);
        check_eq("abort_hold_idle", 32'(hold[2]), 32'd0);
        access(2, 1'b0, 32'h1000_0020, 32'd0, 3, 1'b0, 1'b1, 32'h0BAD_F00D);

        // last word of the window
        access(1, 1'b1, 32'h1000_3FFC, 32'h7777_8888, 1, 1'b0, 1'b0, 32'd0);
        access(1, 1'b0, 32'h1000_3FFC, 32'd0, 1, 1'b0, 1'b1, 32'h7777_8888);

        // request held through ack: re-accepted only after an IDLE cycle
        @(negedge clk);
        set_req(1, 1'b0, 32'h1000_0010, 32'd0);
        @(posedge clk);
        acks = 0;
        for (int i = 0; i < 20 && acks == 0; i++) begin
            @(negedge clk);
            if (ack[1]) acks++;
        end
        check_eq("held_first_ack", 32'(acks), 32'd1);
        @(negedge clk);
        check_eq("held_idle_ack", 32'(ack[1]), 32'd0);
        check_eq("held_idle_hold", 32'(hold[1]), 32'd1);
        @(negedge clk);
        check_eq("held_wait_ack", 32'(ack[1]), 32'd0);
        check_eq("held_wait_hold", 32'(hold[1]), 32'd1);
        @(negedge clk);
        check_eq("held_second_ack", 32'(ack[1]), 32'd1);
        check_eq("held_second_data", rdata[1], 32'hDEAD_BEEF);
        req[1] = 1'b0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
